// File: rtl/div_pkg.sv
// Shared definitions for the restoring-divider control FSM.
package div_pkg;

    // Controller states; encoding kept to 3 bits to match the legacy state register.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CLR  = 3'd1,
        INIT = 3'd2,
        CALC = 3'd3,
        DONE = 3'd4
    } div_state_t;

    // Counter width able to hold 0..iter (cnt reaches iter on the last CALC edge).
    function automatic int unsigned cnt_w(input int unsigned iter);
        return $clog2(iter + 1);
    endfunction

endpackage

// File: rtl/div_ctrl.sv
// Control FSM for a shift/conditional-subtract divider datapath.
// Sequence per operation: CLR, INIT, ITER x CALC, DONE, then back to IDLE.
module div_ctrl
    import div_pkg::*;
#(
    parameter int unsigned ITER = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic ge,
    output logic zero,
    output logic init,
    output logic shift,
    output logic ld,
    output logic ready,
    output logic done
);

    localparam int unsigned CNT_W = cnt_w(ITER);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

    div_state_t       state;
    div_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;

    // State register with asynchronous reset to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Iteration counter: cleared in CLR, counts CALC cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == CLR) begin
            cnt <= '0;
        end else if (state == CALC) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Next-state logic; start is only looked at in IDLE, so it is never queued.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CLR;
            CLR:     state_nxt = INIT;
            INIT:    state_nxt = CALC;
            CALC:    if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore command outputs plus the Mealy remainder-load strobe.
    always_comb begin
        zero  = 1'b0;
        init  = 1'b0;
        shift = 1'b0;
        ready = 1'b0;
        done  = 1'b0;
        case (state)
            IDLE:    ready = 1'b1;
            CLR:     zero  = 1'b1;
            INIT:    init  = 1'b1;
            CALC:    shift = 1'b1;
            DONE:    done  = 1'b1;
            default: ready = 1'b0;
        endcase
        ld = (state == CALC) & ge;
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: ITER=8 and ITER=1 instances on a shared clock/reset.
module tb_div_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic ge = 1'b0;
    logic start1 = 1'b0;
    logic ge1 = 1'b0;

    logic zero, init, shift, ld, ready, done;
    logic zero1, init1, shift1, ld1, ready1, done1;

    int checks = 0;
    int errors = 0;

    // Output vectors ordered {ready, zero, init, shift, ld, done}.
    logic [5:0] o8, o1;
    assign o8 = {ready, zero, init, shift, ld, done};
    assign o1 = {ready1, zero1, init1, shift1, ld1, done1};

    localparam logic [5:0] V_IDLE = 6'b100000;
    localparam logic [5:0] V_CLR  = 6'b010000;
    localparam logic [5:0] V_INIT = 6'b001000;
    localparam logic [5:0] V_CALC = 6'b000100;
    localparam logic [5:0] V_DONE = 6'b000001;

    always #5 clk = ~clk;

    div_ctrl #(.ITER(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .ge(ge),
        .zero(zero), .init(init), .shift(shift), .ld(ld),
        .ready(ready), .done(done)
    );

    div_ctrl #(.ITER(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .ge(ge1),
        .zero(zero1), .init(init1), .shift(shift1), .ld(ld1),
        .ready(ready1), .done(done1)
    );

    task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // One ITER=8 operation. Call just after a negedge with the DUT in IDLE.
    // gepat is applied MSB-first over the CALC cycles; ge=1 elsewhere.
    task automatic op8(input string name, input logic [7:0] gepat, input int repulse, input bit hold);
        logic [5:0] exp;
        logic       gb;
        start = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            start = hold || (i == repulse);
            gb = 1'b1;
            if (i >= 3 && i <= 10) gb = gepat[10 - i];
            ge = gb;
            #1;
            if (i == 1)       exp = V_CLR;
            else if (i == 2)  exp = V_INIT;
            else if (i <= 10) exp = {4'b0001, gb, 1'b0};
            else if (i == 11) exp = V_DONE;
            else              exp = V_IDLE;
            check($sformatf("%s_c%0d", name, i), o8, exp);
        end
    endtask

    // One ITER=1 operation: CLR, INIT, one CALC, DONE, IDLE.
    task automatic op1(input string name, input logic g);
        logic [5:0] exp;
        start1 = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            start1 = 1'b0;
            ge1 = g;
            #1;
            case (i)
                1:       exp = V_CLR;
                2:       exp = V_INIT;
                3:       exp = {4'b0001, g, 1'b0};
                4:       exp = V_DONE;
                default: exp = V_IDLE;
            endcase
            check($sformatf("%s_c%0d", name, i), o1, exp);
        end
    endtask

    initial begin
        // Reset, checked while asserted across a clock edge.
        #2 rst = 1'b1;
        #1 check("rst_hold8", o8, V_IDLE);
        check("rst_hold1", o1, V_IDLE);
        @(negedge clk);
        check("rst_edge8", o8, V_IDLE);
        rst = 1'b0;

        // Idle with start low for five cycles; ge high must not raise ld.
        ge = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1 check($sformatf("idle_%0d", i), o8, V_IDLE);
        end

        // Nominal operation with the ld pattern 1,0,1,1,0,0,1,0.
        op8("nom", 8'b1011_0010, 0, 1'b0);

        // start re-pulsed during CALC is ignored: single done, no follow-up op.
        op8("repulse", 8'b0101_0101, 5, 1'b0);
        @(negedge clk);
        #1 check("repulse_idle", o8, V_IDLE);

        // start held: back-to-back ops with exactly one ready cycle between them.
        op8("b2b_a", 8'hFF, 0, 1'b1);
        op8("b2b_b", 8'h00, 0, 1'b0);

        // Async reset in CALC with cnt=4, between clock edges.
        start = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            start = 1'b0;
            ge = 1'b0;
        end
        #1 check("pre_rst_calc", o8, V_CALC);
        #2 rst = 1'b1;
        #1 check("rst_async", o8, V_IDLE);
        @(negedge clk);
        check("rst_mid_edge", o8, V_IDLE);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1 check($sformatf("post_rst_%0d", i), o8, V_IDLE);
        end
        op8("after_rst", 8'b1000_0001, 0, 1'b0);

        // ITER=1 instance.
        op1("it1_ge1", 1'b1);
        op1("it1_ge0", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 The module SHALL have parameter ITER, default 8, meaning the number of shift/conditional-load iterations per operation (legal range 1..255).
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The module SHALL have port start, input, 1, operation request, sampled only in IDLE.
REQ-005 The module SHALL have port ge, input, 1, datapath flag meaning "partial remainder >= divisor", valid in CALC.
REQ-006 The module SHALL have port zero, output, 1, clear command to the downstream datapath registers.
REQ-007 The module SHALL have port init, output, 1, initial-value load command to the downstream datapath registers.
REQ-008 The module SHALL have port shift, output, 1, shift-one-position command to the datapath.
REQ-009 The module SHALL have port ld, output, 1, remainder-register parallel load (subtract result accepted).
REQ-010 The module SHALL have port ready, output, 1, high only in IDLE.
REQ-011 The module SHALL have port done, output, 1, one-cycle completion pulse.

Function
REQ-012 The FSM SHALL have states IDLE, CLR, INIT, CALC, DONE.
REQ-013 Transitions SHALL be: IDLE->CLR when start=1, else stay; CLR->INIT unconditionally; INIT->CALC unconditionally; CALC->DONE when cnt==ITER-1, else stay; DONE->IDLE unconditionally.
REQ-014 Outputs zero, init, shift, ready and done SHALL be Moore outputs: zero=1 only in CLR, init=1 only in INIT, shift=1 only in CALC, done=1 only in DONE, and ready=1 only in IDLE.
REQ-015 ld SHALL be Mealy: ld = (state==CALC) & ge, with no registering.
REQ-016 At most one of zero, init, done SHALL be high in any cycle, and zero/init SHALL never coincide with shift or ld.
REQ-017 The iteration counter cnt, of width CNT_W, SHALL clear to 0 in CLR and increment by 1 each CALC cycle; it SHALL never wrap within an operation.
REQ-018 Latency SHALL be exactly ITER+3 cycles from the start-sampling edge to the edge ending DONE: 1 CLR + 1 INIT + ITER CALC + 1 DONE.
REQ-019 start asserted in any state other than IDLE SHALL be ignored and SHALL NOT be queued.
REQ-020 start held high continuously SHALL begin a new operation on the first IDLE cycle after DONE, i.e. back-to-back operations with one IDLE cycle between them.
REQ-021 When ITER=1, the FSM SHALL spend exactly one cycle in CALC.
REQ-022 ge SHALL be ignored outside CALC.

Reset
REQ-023 rst=1 SHALL force state=IDLE and cnt=0 asynchronously, independent of clk.
REQ-024 During and immediately after reset, outputs SHALL be ready=1 and zero=init=shift=ld=done=0.
REQ-025 Reset asserted mid-operation, in any state, SHALL abort the operation with no done pulse; the first start after release SHALL begin a fresh operation.

Structure
REQ-026 The state enum (div_state_t) and a CNT_W function/constant, computed as clog2(ITER+1), SHALL live in shared package div_pkg.
REQ-027 The block SHALL use one state register and one counter register, with separate combinational next-state and output logic; no sub-module is required.

Verification
REQ-028 Reset then idle: rst pulse, start=0 for 5 cycles -> ready=1, all command outputs 0, state IDLE throughout.
REQ-029 Nominal, ITER=8: 1-cycle start pulse -> zero high for 1 cycle, then init high for 1 cycle, then shift high for 8 cycles, then done high for 1 cycle; ready returns to 1 after 11 cycles.
REQ-030 ge pattern 1,0,1,1,0,0,1,0 applied across the 8 CALC cycles -> ld equals that pattern cycle-for-cycle, and ld=0 outside CALC even with ge=1.
REQ-031 start re-pulsed during CALC -> ignored; exactly one done pulse; start held high -> two operations separated by exactly one ready cycle.
REQ-032 rst asserted asynchronously in CALC (cnt=4) -> outputs return to reset values before the next clk edge, with no done pulse; a subsequent start completes in 11 cycles.
REQ-033 ITER=1 build: start pulse -> CLR, INIT, one shift cycle, done; total 4 cycles.
